// File: rtl/shift_cmd_issuer.sv
// Purpose: buffers shift requests and issues each to a command-driven shifter as LOAD then SHIFT, returning q.
// Latency: 2+SR_LAT cycles from FIFO pop to rsp_valid (1+SR_LAT when amount is zero); push visible to FSM next cycle.
// Backpressure: req_ready drops when the FIFO is full; a held response (rsp_ready low) stalls popping.

module shift_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full (MSBs differ) from empty (pointers equal).
    assign push_rdy = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
    assign pop_vld  = (wr_ptr != rd_ptr);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;
    assign pop_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module shift_cmd_issuer #(
    parameter int DEPTH  = 4,
    parameter int SR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dir,
    input  logic [4:0]  req_amt,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [7:0]  sr_data,
    output logic [31:0] sr_data_in,
    input  logic [31:0] sr_q,
    output logic        busy
);
    localparam int CW = (SR_LAT > 1) ? $clog2(SR_LAT) : 1;
    localparam logic [7:0] SR_LOAD = 8'h07;
    localparam logic [7:0] SR_NOP  = 8'h00;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b011;

    typedef struct packed {
        logic        dir;
        logic [4:0]  amt;
        logic [31:0] data;
    } req_t;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT} state_t;

    state_t        state, state_nxt;
    req_t          push_ent, head;
    logic          fifo_vld;
    logic          pop;
    logic          capture;
    logic          cur_dir, cur_dir_nxt;
    logic [4:0]    cur_amt, cur_amt_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic [7:0]    sr_data_nxt;
    logic [31:0]   sr_data_in_nxt;
    logic          rsp_valid_nxt;
    logic [31:0]   rsp_data_nxt;

    assign push_ent = '{dir: req_dir, amt: req_amt, data: req_data};

    shift_cmd_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_valid),
        .push_rdy (req_ready),
        .push_dat (push_ent),
        .pop_vld  (fifo_vld),
        .pop_rdy  (pop),
        .pop_dat  (head)
    );

    // Shifter controls are computed one state ahead so the registered outputs line up with the state.
    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        capture        = 1'b0;
        sr_data_nxt    = SR_NOP;
        sr_data_in_nxt = sr_data_in;
        cur_dir_nxt    = cur_dir;
        cur_amt_nxt    = cur_amt;
        wait_cnt_nxt   = wait_cnt;
        case (state)
            IDLE: begin
                if (fifo_vld && (!rsp_valid || rsp_ready)) begin
                    pop            = 1'b1;
                    state_nxt      = LOAD;
                    sr_data_nxt    = SR_LOAD;
                    sr_data_in_nxt = head.data;
                    cur_dir_nxt    = head.dir;
                    cur_amt_nxt    = head.amt;
                end
            end
            LOAD: begin
                if (cur_amt != 5'd0) begin
                    state_nxt   = SHIFT;
                    sr_data_nxt = {cur_amt, cur_dir ? OP_SHR : OP_SHL};
                end else begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = CW'(SR_LAT - 1);
                end
            end
            SHIFT: begin
                state_nxt    = WAIT;
                wait_cnt_nxt = CW'(SR_LAT - 1);
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        if (capture) begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = sr_q;
        end else if (rsp_ready) begin
            rsp_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr_data    <= SR_NOP;
            sr_data_in <= '0;
            cur_dir    <= 1'b0;
            cur_amt    <= '0;
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state      <= state_nxt;
            sr_data    <= sr_data_nxt;
            sr_data_in <= sr_data_in_nxt;
            cur_dir    <= cur_dir_nxt;
            cur_amt    <= cur_amt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
        end
    end

    assign busy = fifo_vld || (state != IDLE) || rsp_valid;
endmodule

// File: doc/shift_cmd_issuer.md
Name: shift_cmd_issuer

Overview:
Initiator-side front end for the 32-bit command-driven shift register. It accepts shift requests (operand, direction, amount) on a valid/ready interface and buffers them in a small FIFO. It then drives the shift register's 8-bit control word and 32-bit data input as a LOAD then SHIFT sequence, and captures the shifter output `q`. Results are returned on a valid/ready response channel. It sits between the datapath control logic and the shift register instance.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, >=2).
- SR_LAT, 1, cycles from the shift command's clock edge until `sr_q` is sampled (>=1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request FIFO not full.
- `req_dir`  in  1  0 = shift left, 1 = shift right (logical).
- `req_amt`  in  5  shift amount, 0..31.
- `req_data`  in  32  operand.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  32  shifted result.
- `sr_data`  out  8  control word to the shift register: [2:0] op, [7:3] amount.
- `sr_data_in`  out  32  load value to the shift register.
- `sr_q`  in  32  shift register output.
- `busy`  out  1  FIFO non-empty, or state != IDLE, or `rsp_valid`.

Behaviour:
- Control encoding: op 3'b111 = LOAD (amount field 0, i.e. 8'h07); 3'b001 = SHL; 3'b011 = SHR; 8'h00 = NOP. Example: SHL by 6 = 8'b00110_001.
- Reset (`rst` = 0, asynchronous):
  - state IDLE, FIFO empty, `rsp_valid` = 0, `rsp_data` = 0.
  - `sr_data` = 8'h00, `sr_data_in` = 0, WAIT counter = 0.
  - Any in-flight request is discarded.
- Push:
  - `req_ready` = !full (combinational); no same-cycle bypass when full.
  - On an edge with `req_valid` && `req_ready`, {dir, amt, data} is written to the FIFO.
  - An entry pushed at edge E is visible to the FSM from E+1.
- FSM states: IDLE, LOAD, SHIFT, WAIT.
  - IDLE: if FIFO non-empty and the response slot is free (`!rsp_valid` or `rsp_ready` this cycle), pop the head at the edge and go to LOAD. Otherwise stay in IDLE.
  - LOAD (1 cycle): `sr_data` = 8'h07, `sr_data_in` = operand. Next state is SHIFT if amt != 0, else WAIT.
  - SHIFT (1 cycle): `sr_data` = {amt, dir ? 3'b011 : 3'b001}. Next state WAIT.
  - WAIT (SR_LAT cycles): `sr_data` = NOP. On the last WAIT edge, `rsp_data` <= `sr_q`, `rsp_valid` <= 1, and the FSM goes to IDLE.
- In IDLE and WAIT, `sr_data` = 8'h00 and `sr_data_in` holds the last operand.
- `sr_data` and `sr_data_in` are registered outputs, so they change only on edges.
- Latency from pop edge to `rsp_valid` rising:
  - 2 + SR_LAT cycles when amt != 0;
  - 1 + SR_LAT cycles when amt = 0 (result equals the operand).
- Response handshake:
  - `rsp_valid` and `rsp_data` are held stable until `rsp_valid` && `rsp_ready`.
  - On that edge `rsp_valid` clears, unless a new capture occurs on the same edge, in which case it stays 1 with the new data.
  - A consumer that never asserts `rsp_ready` stalls popping. The FIFO then fills and `req_ready` drops.
- Ordering: responses are returned strictly in request order; exactly one response per accepted request.
- Simultaneous push and pop on the same edge are both honoured; the FIFO level is unchanged.
- FIFO pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset asserted mid-sequence:
  - `sr_data` is forced to NOP immediately;
  - no response is produced for the aborted request;
  - `req_ready` = 1 after release.

Test Plan:
- Single SHL: req {dir 0, amt 1, data 32'h1} -> `sr_data` shows 8'h07 then 8'h09; `rsp_data` = 32'h2 four cycles after acceptance (SR_LAT = 1).
- Queued burst, `rsp_ready` = 1:
  - requests SHL 6 on 1, SHL 24 on 1, SHR 1 on 32'h80000000, SHR 6 on 32'h1000;
  - required responses in order: 32'h40, 32'h01000000, 32'h40000000, 32'h40.
- Zero amount: req {amt 0, data 32'hff0} -> no SHIFT cycle, `rsp_data` = 32'hff0 three cycles after acceptance.
- Backpressure:
  - hold `rsp_ready` = 0 and push DEPTH+2 requests -> `req_ready` = 0 once the FIFO holds DEPTH entries;
  - `rsp_valid` stays high with the first result unchanged;
  - release -> all accepted results drain in order, none lost or duplicated.
- Boundaries:
  - SHR 31 on 32'hffffffff -> 32'h1;
  - SHL 31 on 32'h3 -> 32'h80000000;
  - SHL 24 on 32'hff0 -> 32'hf0000000.
- Reset during SHIFT: assert `rst` = 0 mid-sequence -> `sr_data` = 8'h00 without a clock edge, `rsp_valid` = 0, FIFO empty; a subsequent request SHR 4 on 32'hff0 -> 32'hff.
